// File: rtl/a_res_sched_if.sv
// a_res_sched_if: issue/check/write-port signal bundle for the A-register reservation scheduler
interface a_res_sched_if #(
  parameter int NUM_AREG = 8,
  parameter int DELAY_W  = 4,
  parameter int SRC_W    = 4,
  parameter int AW       = $clog2(NUM_AREG)
);
  logic                i_issue;
  logic [AW-1:0]       i_dest;
  logic [DELAY_W-1:0]  i_delay;
  logic [SRC_W-1:0]    i_src;
  logic [AW-1:0]       i_chk_j;
  logic [AW-1:0]       i_chk_k;
  logic [2:0]          i_chk_en;
  logic                i_flush;
  logic                o_hold;
  logic [NUM_AREG-1:0] o_busy;
  logic                o_wr_en;
  logic [AW-1:0]       o_wr_addr;
  logic [SRC_W-1:0]    o_wr_src;
  logic                o_issue_drop;
  modport master (
    output i_issue, i_dest, i_delay, i_src, i_chk_j, i_chk_k, i_chk_en, i_flush,
    input  o_hold, o_busy, o_wr_en, o_wr_addr, o_wr_src, o_issue_drop
  );
  modport slave (
    input  i_issue, i_dest, i_delay, i_src, i_chk_j, i_chk_k, i_chk_en, i_flush,
    output o_hold, o_busy, o_wr_en, o_wr_addr, o_wr_src, o_issue_drop
  );
endinterface

// File: rtl/a_res_sched.sv
// a_res_sched: per-A-register latency countdown with issue hold, single write-port slot arbitration and flush
module a_res_sched #(
  parameter int NUM_AREG = 8,
  parameter int DELAY_W  = 4,
  parameter int SRC_W    = 4,
  localparam int AW      = $clog2(NUM_AREG)
) (
  input logic clk,
  input logic rst,
  a_res_sched_if.slave bus
);
  logic [DELAY_W-1:0]  cnt [NUM_AREG];
  logic [SRC_W-1:0]    src [NUM_AREG];
  logic [NUM_AREG-1:0] busy;
  logic [DELAY_W:0]    slot;
  logic                issue_nz, slot_hit, hold, accept, drop;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [SRC_W-1:0]    wr_src;
  // a result with count c writes c-1 cycles from now; the new one writes i_delay from now
  always_comb begin
    slot     = {1'b0, bus.i_delay} + (DELAY_W+1)'(1);
    issue_nz = bus.i_issue & (bus.i_delay != '0);
    slot_hit = 1'b0;
    for (int r = 0; r < NUM_AREG; r++) begin
      busy[r]  = cnt[r] != '0;
      slot_hit = slot_hit | ({1'b0, cnt[r]} == slot);
    end
    hold   = (bus.i_chk_en[0] & busy[bus.i_chk_j]) | (bus.i_chk_en[1] & busy[bus.i_chk_k]) |
             (bus.i_chk_en[2] & busy[bus.i_dest]) | (issue_nz & slot_hit);
    accept = issue_nz & ~hold & ~bus.i_flush;
  end
  // descending scan so the lowest-numbered expiring register wins if two ever collide
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_src  = '0;
    for (int r = NUM_AREG - 1; r >= 0; r--) begin
      if (cnt[r] == DELAY_W'(1)) begin
        wr_en   = 1'b1;
        wr_addr = AW'(r);
        wr_src  = src[r];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_AREG; r++) begin
        cnt[r] <= '0;
        src[r] <= '0;
      end
      drop <= 1'b0;
    end else begin
      drop <= issue_nz & hold & ~bus.i_flush;
      for (int r = 0; r < NUM_AREG; r++) begin
        cnt[r] <= bus.i_flush ? '0 :
                  (accept && bus.i_dest == AW'(r)) ? bus.i_delay :
                  cnt[r] - DELAY_W'(cnt[r] != '0);
        if (accept && bus.i_dest == AW'(r)) src[r] <= bus.i_src;
      end
    end
  end
  assign bus.o_hold       = hold;
  assign bus.o_busy       = busy;
  assign bus.o_wr_en      = wr_en;
  assign bus.o_wr_addr    = wr_addr;
  assign bus.o_wr_src     = wr_src;
  assign bus.o_issue_drop = drop;
endmodule
